// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO: CPU memory-map addresses and status bit layout.
package uart_rx_fifo_pkg;

    localparam logic [7:0] RX_DATA_ADDR = 8'd252;
    localparam logic [7:0] RX_STAT_ADDR = 8'd254;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;

    function automatic logic [7:0] pack_status(input logic not_empty, input logic full,
                                               input logic ovf);
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_NOT_EMPTY] = not_empty;
        s[STAT_FULL]      = full;
        s[STAT_OVF]       = ovf;
        return s;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ptr_ctrl.sv
// FIFO bookkeeping: read/write pointers, fill count and push/pop/flush acceptance.
module fifo_ptr_ctrl
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic [PTR_W:0]   count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             wr_en_o,
    output logic             drop_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

    // A pop on a full FIFO frees the head slot in the same cycle, so the push can land there.
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;
    assign drop_o  = push_i & full_o & ~pop_ok & ~flush_i;
    assign wr_en_o = push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO (first-word fall-through) with status and interrupt request.
// Define UART_RX_FIFO_THRESH_IRQ_EN to raise int_req on fill level >= THRESH instead of non-empty.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int THRESH = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rx_flag,
    input  logic [7:0]     rx_byte,
    input  logic           pop,
    input  logic           flush,
    input  logic           clr_ovf,
    output logic [7:0]     rd_data,
    output logic [PTR_W:0] count,
    output logic           empty,
    output logic           full,
    output logic           overflow,
    output logic [7:0]     status,
    output logic           int_req
);

    if (DEPTH != (1 << PTR_W) || DEPTH < 2 || DEPTH > 64 || THRESH < 1 || THRESH > DEPTH)
    begin : g_bad_cfg
        $error("uart_rx_fifo: inconsistent DEPTH/PTR_W/THRESH");
    end

    logic             rx_flag_q;
    logic             push;
    logic             wr_en, drop;
    logic             overflow_q, overflow_d;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [7:0]       mem_q [DEPTH];

    // The UART flag is a level; only its rising edge is a new byte.
    assign push = rx_flag & ~rx_flag_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rx_flag_q <= 1'b0;
        else       rx_flag_q <= rx_flag;
    end

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clock    (clock),
        .reset    (reset),
        .push_i   (push),
        .pop_i    (pop),
        .flush_i  (flush),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .count_o  (count),
        .empty_o  (empty),
        .full_o   (full),
        .wr_en_o  (wr_en),
        .drop_o   (drop)
    );

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr] <= rx_byte;
    end

    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr];

    // A drop in the same cycle as a clear keeps the flag set so the loss is not hidden.
    always_comb begin
        overflow_d = overflow_q;
        if (drop)         overflow_d = 1'b1;
        else if (clr_ovf) overflow_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
    assign status   = pack_status(~empty, full, overflow_q);

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    assign int_req = (count >= (PTR_W+1)'(THRESH)) | overflow_q;
`else
    assign int_req = ~empty | overflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios then random traffic against a queue model.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int THRESH = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           rx_flag;
    logic [7:0]     rx_byte;
    logic           pop, flush, clr_ovf;
    logic [7:0]     rd_data;
    logic [PTR_W:0] count;
    logic           empty, full, overflow;
    logic [7:0]     status;
    logic           int_req;

    uart_rx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .THRESH(THRESH)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_flag  (rx_flag),
        .rx_byte  (rx_byte),
        .pop      (pop),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .status   (status),
        .int_req  (int_req)
    );

    always #5 clock = ~clock;

    // Reference model: a byte queue plus sticky overflow and the previous flag level.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_prev;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string ctx);
        int         sz;
        logic [7:0] e_rd;
        logic       e_irq;
        sz   = mq.size();
        e_rd = (sz > 0) ? mq[0] : 8'h00;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        e_irq = (sz >= THRESH) || m_ovf;
`else
        e_irq = (sz != 0) || m_ovf;
`endif
        chk({ctx, ".count"},    32'(count),    32'(sz));
        chk({ctx, ".empty"},    32'(empty),    32'(sz == 0));
        chk({ctx, ".full"},     32'(full),     32'(sz == DEPTH));
        chk({ctx, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({ctx, ".rd_data"},  32'(rd_data),  32'(e_rd));
        chk({ctx, ".status"},   32'(status),
            32'({5'b0, m_ovf, (sz == DEPTH), (sz != 0)}));
        chk({ctx, ".int_req"},  32'(int_req),  32'(e_irq));
    endtask

    // Apply one rising edge to the model using the currently driven inputs.
    task automatic model_step();
        bit push, pop_ok, drop;
        int sz;
        push   = rx_flag && !m_prev;
        m_prev = rx_flag;
        sz     = mq.size();
        drop   = 0;
        if (flush) begin
            mq.delete();
        end else begin
            pop_ok = pop && (sz > 0);
            if (pop_ok) void'(mq.pop_front());
            if (push) begin
                if (sz < DEPTH || pop_ok) mq.push_back(rx_byte);
                else                      drop = 1;
            end
        end
        if (drop)         m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
    endtask

    task automatic cyc(input string ctx);
        @(posedge clock);
        model_step();
        #1;
        check_all(ctx);
        pop     = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic with_pop, input string ctx);
        rx_flag = 1'b1;
        rx_byte = b;
        pop     = with_pop;
        cyc(ctx);
        rx_flag = 1'b0;
        cyc(ctx);
    endtask

    task automatic do_reset(input string ctx);
        reset = 1'b1;
        mq.delete();
        m_ovf  = 0;
        m_prev = 0;
        #2;
        check_all(ctx);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rx_flag = 1'b0;
        rx_byte = 8'h00;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;
        do_reset("reset");

        // Held flag produces a single push.
        rx_flag = 1'b1;
        rx_byte = 8'hA5;
        repeat (5) cyc("hold");
        rx_flag = 1'b0;
        cyc("hold_fall");
        chk("one_push.count",  32'(count),   32'd1);
        chk("one_push.rd",     32'(rd_data), 32'hA5);
        chk("one_push.status", 32'(status),  32'h01);
        pop = 1'b1;
        cyc("drain_a5");

        // Fill, overflow, drain in order.
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0, "fill");
        push_byte(8'h18, 1'b0, "ovf");
        chk("ovf.status", 32'(status), 32'h07);
        for (int i = 0; i < 8; i++) begin
            chk("drain.order", 32'(rd_data), 32'(8'h10 + 8'(i)));
            pop = 1'b1;
            cyc("drain");
        end
        chk("drain.rd_empty", 32'(rd_data), 32'h00);
        clr_ovf = 1'b1;
        cyc("clr_ovf");

        // Push and pop together while full: no overflow, new byte goes to the tail.
        for (int i = 0; i < 8; i++) push_byte(8'($urandom_range(0, 255)), 1'b0, "refill");
        push_byte(8'h55, 1'b1, "full_pushpop");
        chk("full_pushpop.count", 32'(count),    32'd8);
        chk("full_pushpop.ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pop = 1'b1;
            cyc("full_drain");
        end
        chk("full_pushpop.last", 32'(rd_data), 32'h55);
        pop = 1'b1;
        cyc("full_drain_last");

        // Push and pop together while empty: pop ignored.
        push_byte(8'h3C, 1'b1, "empty_pushpop");
        chk("empty_pushpop.count", 32'(count),   32'd1);
        chk("empty_pushpop.rd",    32'(rd_data), 32'h3C);

        // Flush discards a same-cycle push.
        push_byte(8'h21, 1'b0, "three");
        push_byte(8'h22, 1'b0, "three");
        rx_flag = 1'b1;
        rx_byte = 8'h23;
        flush   = 1'b1;
        cyc("flush");
        rx_flag = 1'b0;
        cyc("flush_after");
        chk("flush.count", 32'(count), 32'd0);

        // Clear in the same cycle as a drop: set wins.
        for (int i = 0; i < 8; i++) push_byte(8'(i * 3), 1'b0, "fill2");
        rx_flag = 1'b1;
        rx_byte = 8'hEE;
        clr_ovf = 1'b1;
        cyc("clr_vs_drop");
        rx_flag = 1'b0;
        cyc("clr_vs_drop2");
        chk("clr_vs_drop.ovf", 32'(overflow), 32'd1);

        // Threshold boundary for the interrupt.
        flush   = 1'b1;
        clr_ovf = 1'b1;
        cyc("irq_clear");
        push_byte(8'h01, 1'b0, "irq1");
`ifndef UART_RX_FIFO_THRESH_IRQ_EN
        chk("irq.count1", 32'(int_req), 32'd1);
`endif
        push_byte(8'h02, 1'b0, "irq2");
        push_byte(8'h03, 1'b0, "irq3");
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        chk("irq.count3", 32'(int_req), 32'd0);
`endif
        push_byte(8'h04, 1'b0, "irq4");
        chk("irq.count4", 32'(int_req), 32'd1);

        // Reset with the flag still high: one push on the first clock after release.
        rx_flag = 1'b1;
        rx_byte = 8'h77;
        #1;
        do_reset("reset_mid");
        cyc("post_reset");
        chk("post_reset.rd", 32'(rd_data), 32'h77);
        rx_flag = 1'b0;
        cyc("post_reset_fall");

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                if (!rx_flag) rx_byte = 8'($urandom_range(0, 255));
                rx_flag = ~rx_flag;
            end
            pop     = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 59) == 0);
            clr_ovf = ($urandom_range(0, 19) == 0);
            cyc("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between the UART receiver and the CPU's memory-mapped read path.
- Detects each new received byte from the UART's level receive flag and pushes it into a first-word-fall-through FIFO.
- The CPU pops one byte per read of the RX data address, so back-to-back bytes are not lost while software is busy.
- Also supplies status bits and an interrupt request to the interrupt logic.

Parameters:
- DEPTH, 8, number of byte entries; power of two, 2..64.
- PTR_W, 3, log2(DEPTH); pointer width.
- THRESH, 4, fill level for the threshold interrupt (used only with the optional feature); 1..DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_flag  input  1  UART receive-complete flag (level); each rising edge marks one new byte.
- rx_byte  input  8  UART received byte; stable while rx_flag is high.
- pop  input  1  one-cycle pulse; CPU read of the RX data address.
- flush  input  1  one-cycle pulse; empties the FIFO.
- clr_ovf  input  1  one-cycle pulse; clears the overflow flag.
- rd_data  output  8  head entry; 8'h00 when empty.
- count  output  PTR_W+1  current fill level, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set when a byte is dropped.
- status  output  8  {5'b0, overflow, full, ~empty}; mux source for the status read address.
- int_req  output  1  level interrupt request.

Behaviour:
- Reset values:
  - Pointers 0, count 0, overflow 0.
  - Edge register rx_flag_q 0.
  - Storage contents are don't-care; rd_data is forced to 8'h00 while empty.
  - empty=1, full=0, status=8'h00, int_req=0.
- Push detect:
  - push = rx_flag & ~rx_flag_q.
  - rx_flag_q <= rx_flag every cycle.
  - A flag held high for N cycles produces exactly one push.
  - Reset mid-byte: rx_flag_q clears; if rx_flag is still high after reset, one push occurs on the first clock after reset.
- Write: on push and not full, mem[wr_ptr] <= rx_byte and wr_ptr increments, wrapping modulo DEPTH.
- Read:
  - rd_data = mem[rd_ptr] combinationally (zero latency).
  - On pop and not empty, rd_ptr increments modulo DEPTH.
  - pop while empty is ignored; no underflow state.
- Count update:
  - +1 on accepted push only.
  - -1 on accepted pop only.
  - Unchanged when both are accepted.
- Simultaneous events:
  - push+pop while empty: push accepted, pop ignored; count becomes 1.
  - push+pop while full: both accepted; count stays DEPTH; the new byte lands in the slot vacated by the head. No overflow.
  - push while full, no pop: byte dropped, overflow <= 1, pointers unchanged.
  - flush: both pointers and count go to 0 and any same-cycle push/pop is discarded; overflow is unaffected.
  - clr_ovf: overflow <= 0, except when the same cycle drops a byte, in which case set wins.
- Outputs are registered-derived: empty/full/status reflect state after the clock edge, so they lag a push by 1 cycle. The CPU sees a new byte in the cycle after the rx_flag rise.
- int_req (feature off): int_req = ~empty | overflow.

Optional Feature:
- Macro: UART_RX_FIFO_THRESH_IRQ_EN.
- Defined: int_req = (count >= THRESH) | overflow. Compare is width-extended to PTR_W+1 bits. THRESH=DEPTH fires only when full.
- Undefined: int_req = ~empty | overflow; THRESH is unused.

Decomposition:
- Shared package/header:
  - RX_DATA_ADDR (8'd252) and RX_STAT_ADDR (8'd254) memory-map constants.
  - Status bit-index constants STAT_NOT_EMPTY=0, STAT_FULL=1, STAT_OVF=2.
- One natural sub-module: fifo_ptr_ctrl, which owns the pointers, count, empty/full, and the accept logic for push/pop/flush.
- The top level keeps the edge detector, storage array, overflow flag, status and int_req.

Test Plan:
- Reset, then rx_flag rises with rx_byte=8'hA5 and is held 5 cycles → count=1 from the next cycle, rd_data=8'hA5, status=8'h01; exactly one push.
- Push 8 bytes 8'h10..8'h17, then a 9th byte 8'h18 → full=1, overflow=1, status=8'h07. Then pop 8 times → rd_data sequence 8'h10..8'h17, empty=1, rd_data=8'h00.
- With FIFO full, push 8'h55 and pop in the same cycle → count stays 8, overflow stays 0, and the last byte popped out after 7 more pops is 8'h55.
- FIFO empty, push 8'h3C and pop in the same cycle → count=1, rd_data=8'h3C.
- With 3 entries, assert flush while rx_flag rises → count=0, empty=1; overflow is unchanged. Then clr_ovf with a simultaneous drop → overflow stays 1.
- With UART_RX_FIFO_THRESH_IRQ_EN defined and THRESH=4 → int_req=0 at count 3 and 1 at count 4. With the macro undefined → int_req=1 at count 1.
